// File: rtl/tdes_pkg.sv
// Shared types and helpers for the triple-DES sequencer.
// The pass table maps (request mode, pass index) to the core direction and key slot.
package tdes_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } tdes_state_e;

  localparam logic [1:0] ERR_OK      = 2'b00;
  localparam logic [1:0] ERR_KEY     = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;

  localparam logic [1:0] KEY_K1 = 2'd0;
  localparam logic [1:0] KEY_K2 = 2'd1;
  localparam logic [1:0] KEY_K3 = 2'd2;

  // EDE: encrypt runs E/K1, D/K2, E/K3; decrypt mirrors it as D/K3, E/K2, D/K1
  function automatic logic [2:0] pass_sel(input logic mode, input logic [1:0] pass);
    logic [2:0] sel;
    case ({mode, pass})
      3'b0_00: sel = {1'b0, KEY_K1};
      3'b0_01: sel = {1'b1, KEY_K2};
      3'b0_10: sel = {1'b0, KEY_K3};
      3'b1_00: sel = {1'b1, KEY_K3};
      3'b1_01: sel = {1'b0, KEY_K2};
      3'b1_10: sel = {1'b1, KEY_K1};
      default: sel = {1'b0, KEY_K1};
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/tdes_seq.sv
// Triple-DES sequencer: latches one request, runs the owned DES core three times (EDE)
// with a per-pass watchdog, and holds the result until the downstream accepts it.
module tdes_seq
  import tdes_pkg::*;
#(
  parameter int DATA_W  = 64,
  parameter int KEY_W   = 64,
  parameter int TIMEOUT = 255
) (
  input  logic              clk_in,
  input  logic              rst_n_in,
  input  logic              req_valid_in,
  output logic              req_ready_out,
  input  logic              req_mode_in,
  input  logic [DATA_W-1:0] req_data_in,
  input  logic [KEY_W-1:0]  req_key1_in,
  input  logic [KEY_W-1:0]  req_key2_in,
  input  logic [KEY_W-1:0]  req_key3_in,
  output logic              rsp_valid_out,
  input  logic              rsp_ready_in,
  output logic [DATA_W-1:0] rsp_data_out,
  output logic [1:0]        rsp_err_out,
  output logic              core_start_out,
  output logic              core_mode_out,
  output logic [KEY_W-1:0]  core_key_out,
  output logic [DATA_W-1:0] core_data_out,
  input  logic              core_ready_in,
  input  logic              core_done_in,
  input  logic [DATA_W-1:0] core_data_in,
  input  logic              core_key_err_in
);

  localparam int WD_W = $clog2(TIMEOUT + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);
  localparam logic [WD_W-1:0] WD_MAX  = WD_W'(TIMEOUT);

  tdes_state_e       state_r, state_nxt_s;
  logic [1:0]        pass_r;
  logic [WD_W-1:0]   wdog_r;
  logic              mode_r;
  logic [DATA_W-1:0] data_r;
  logic [KEY_W-1:0]  k1_r, k2_r, k3_r;

  logic              rsp_valid_r;
  logic [DATA_W-1:0] rsp_data_r;
  logic [1:0]        rsp_err_r;
  logic              core_start_r;
  logic              core_mode_r;
  logic [KEY_W-1:0]  core_key_r;
  logic [DATA_W-1:0] core_data_r;

  logic              accept_s, issue_s, next_pass_s, finish_s;
  logic              fail_key_s, fail_to_s, rsp_take_s;
  logic [2:0]        sel_s;
  logic [KEY_W-1:0]  pass_key_s;

  // State register
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic and one-cycle event strobes for the datapath
  always_comb begin
    state_nxt_s = state_r;
    accept_s    = 1'b0;
    issue_s     = 1'b0;
    next_pass_s = 1'b0;
    finish_s    = 1'b0;
    fail_key_s  = 1'b0;
    fail_to_s   = 1'b0;
    rsp_take_s  = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (req_valid_in) begin
          accept_s    = 1'b1;
          state_nxt_s = S_ISSUE;
        end else begin
          state_nxt_s = S_IDLE;
        end
      end
      S_ISSUE: begin
        if (core_ready_in) begin
          issue_s     = 1'b1;
          state_nxt_s = S_WAIT;
        end else begin
          state_nxt_s = S_ISSUE;
        end
      end
      S_WAIT: begin
        // a key rejection outranks a done reported in the same cycle
        if (core_key_err_in) begin
          fail_key_s  = 1'b1;
          state_nxt_s = S_RESP;
        end else if (core_done_in) begin
          if (pass_r == 2'd2) begin
            finish_s    = 1'b1;
            state_nxt_s = S_RESP;
          end else begin
            next_pass_s = 1'b1;
            state_nxt_s = S_ISSUE;
          end
        end else if (wdog_r == WD_LAST) begin
          fail_to_s   = 1'b1;
          state_nxt_s = S_RESP;
        end else begin
          state_nxt_s = S_WAIT;
        end
      end
      S_RESP: begin
        if (rsp_ready_in) begin
          rsp_take_s  = 1'b1;
          state_nxt_s = S_IDLE;
        end else begin
          state_nxt_s = S_RESP;
        end
      end
      default: begin
        state_nxt_s = S_IDLE;
      end
    endcase
  end

  // Key selection for the pass about to be issued
  always_comb begin
    sel_s = pass_sel(mode_r, pass_r);
    case (sel_s[1:0])
      KEY_K1:  pass_key_s = k1_r;
      KEY_K2:  pass_key_s = k2_r;
      default: pass_key_s = k3_r;
    endcase
  end

  // Request latch, pass counter, watchdog and core drive registers
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      pass_r       <= 2'd0;
      wdog_r       <= '0;
      mode_r       <= 1'b0;
      data_r       <= '0;
      k1_r         <= '0;
      k2_r         <= '0;
      k3_r         <= '0;
      core_start_r <= 1'b0;
      core_mode_r  <= 1'b0;
      core_key_r   <= '0;
      core_data_r  <= '0;
    end else begin
      core_start_r <= issue_s;
      if (accept_s) begin
        mode_r <= req_mode_in;
        data_r <= req_data_in;
        k1_r   <= req_key1_in;
        k2_r   <= req_key2_in;
        k3_r   <= req_key3_in;
        pass_r <= 2'd0;
      end
      if (next_pass_s) begin
        data_r <= core_data_in;
        pass_r <= pass_r + 2'd1;
      end
      if (issue_s) begin
        core_mode_r <= sel_s[2];
        core_key_r  <= pass_key_s;
        core_data_r <= data_r;
        wdog_r      <= '0;
      end else if ((state_r == S_WAIT) && (wdog_r != WD_MAX)) begin
        wdog_r <= wdog_r + WD_W'(1);
      end
    end
  end

  // Response registers: errors return a zero block
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      rsp_valid_r <= 1'b0;
      rsp_data_r  <= '0;
      rsp_err_r   <= ERR_OK;
    end else if (finish_s) begin
      rsp_valid_r <= 1'b1;
      rsp_data_r  <= core_data_in;
      rsp_err_r   <= ERR_OK;
    end else if (fail_key_s) begin
      rsp_valid_r <= 1'b1;
      rsp_data_r  <= '0;
      rsp_err_r   <= ERR_KEY;
    end else if (fail_to_s) begin
      rsp_valid_r <= 1'b1;
      rsp_data_r  <= '0;
      rsp_err_r   <= ERR_TIMEOUT;
    end else if (rsp_take_s) begin
      rsp_valid_r <= 1'b0;
      rsp_data_r  <= '0;
      rsp_err_r   <= ERR_OK;
    end
  end

  assign req_ready_out  = (state_r == S_IDLE);
  assign rsp_valid_out  = rsp_valid_r;
  assign rsp_data_out   = rsp_data_r;
  assign rsp_err_out    = rsp_err_r;
  assign core_start_out = core_start_r;
  assign core_mode_out  = core_mode_r;
  assign core_key_out   = core_key_r;
  assign core_data_out  = core_data_r;

endmodule

// File: tb/tb_tdes_seq.sv
// Bench for tdes_seq: a stand-in DES core with programmable latency, hang and key-error
// injection, plus an EDE reference model built from the pass table.
module tb_tdes_seq;

  logic        clk_in = 1'b0;
  logic        rst_n_in;
  logic        req_valid_in, req_ready_out, req_mode_in;
  logic [63:0] req_data_in, req_key1_in, req_key2_in, req_key3_in;
  logic        rsp_valid_out, rsp_ready_in;
  logic [63:0] rsp_data_out;
  logic [1:0]  rsp_err_out;
  logic        core_start_out, core_mode_out;
  logic [63:0] core_key_out, core_data_out;
  logic        core_ready_in, core_done_in, core_key_err_in;
  logic [63:0] core_data_in;

  int compared = 0;
  int mismatched = 0;
  int cyc = 0;
  int starts = 0;
  int dbl_starts = 0;
  int stab_err = 0;
  int lcore = 3;
  int err_at = -1;
  int c_n = 0;
  int c_cnt = 0;
  logic hang = 1'b0;
  logic c_busy = 1'b0;
  logic prev_start = 1'b0;
  logic [63:0] c_key, c_dat, c_res, cal_c;
  logic        log_mode[$];
  logic [63:0] log_key[$];
  int          log_cyc[$];

  localparam logic [63:0] KV   = 64'h1334_5779_9BBC_DFF1;
  localparam logic [63:0] PT   = 64'h0123_4567_89AB_CDEF;
  localparam logic [63:0] CT   = 64'h85E8_1354_0F0A_B405;

  tdes_seq #(.DATA_W(64), .KEY_W(64), .TIMEOUT(255)) dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in),
    .req_valid_in(req_valid_in), .req_ready_out(req_ready_out), .req_mode_in(req_mode_in),
    .req_data_in(req_data_in), .req_key1_in(req_key1_in), .req_key2_in(req_key2_in),
    .req_key3_in(req_key3_in), .rsp_valid_out(rsp_valid_out), .rsp_ready_in(rsp_ready_in),
    .rsp_data_out(rsp_data_out), .rsp_err_out(rsp_err_out), .core_start_out(core_start_out),
    .core_mode_out(core_mode_out), .core_key_out(core_key_out), .core_data_out(core_data_out),
    .core_ready_in(core_ready_in), .core_done_in(core_done_in), .core_data_in(core_data_in),
    .core_key_err_in(core_key_err_in)
  );

  always #5 clk_in = ~clk_in;
  always @(posedge clk_in) cyc <= cyc + 1;

  // Keyed, invertible stand-in for DES, calibrated so the classic test vector holds
  function automatic int rn(input logic [63:0] k);
    return (int'(k[5:0]) % 63) + 1;
  endfunction
  function automatic logic [63:0] rotl(input logic [63:0] x, input int n);
    return (x << n) | (x >> (64 - n));
  endfunction
  function automatic logic [63:0] rotr(input logic [63:0] x, input int n);
    return rotl(x, 64 - n);
  endfunction
  function automatic logic [63:0] core_e(input logic [63:0] k, input logic [63:0] x);
    return rotl(x ^ k ^ cal_c, rn(k));
  endfunction
  function automatic logic [63:0] core_d(input logic [63:0] k, input logic [63:0] y);
    return rotr(y, rn(k)) ^ k ^ cal_c;
  endfunction
  function automatic logic [63:0] tdes_model(input logic m, input logic [63:0] d,
                                             input logic [63:0] k1, k2, k3);
    if (m == 1'b0) return core_e(k3, core_d(k2, core_e(k1, d)));
    else           return core_d(k1, core_e(k2, core_d(k3, d)));
  endfunction

  // DES core model: one pass per start, done after lcore cycles unless hung
  always @(negedge clk_in) begin
    core_done_in    <= 1'b0;
    core_key_err_in <= 1'b0;
    prev_start      <= core_start_out;
    if (!rst_n_in) begin
      c_busy <= 1'b0;
    end else if (core_start_out) begin
      if (prev_start) dbl_starts <= dbl_starts + 1;
      starts <= starts + 1;
      c_n    <= starts + 1;
      log_mode.push_back(core_mode_out);
      log_key.push_back(core_key_out);
      log_cyc.push_back(cyc);
      c_key  <= core_key_out;
      c_dat  <= core_data_out;
      c_res  <= core_mode_out ? core_d(core_key_out, core_data_out)
                              : core_e(core_key_out, core_data_out);
      c_busy <= 1'b1;
      c_cnt  <= lcore;
    end else if (c_busy) begin
      if (core_key_out !== c_key || core_data_out !== c_dat) stab_err <= stab_err + 1;
      if (c_cnt == 1) begin
        c_busy <= 1'b0;
        if (!hang) begin
          core_done_in <= 1'b1;
          core_data_in <= c_res;
        end
        if (c_n == err_at) core_key_err_in <= 1'b1;
      end else begin
        c_cnt <= c_cnt - 1;
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req_ready"}, 64'(req_ready_out), 64'd1);
    check({tag, "_rsp_valid"}, 64'(rsp_valid_out), 64'd0);
    check({tag, "_rsp_data"}, rsp_data_out, 64'd0);
    check({tag, "_rsp_err"}, 64'(rsp_err_out), 64'd0);
    check({tag, "_core_start"}, 64'(core_start_out), 64'd0);
    check({tag, "_core_mode"}, 64'(core_mode_out), 64'd0);
    check({tag, "_core_key"}, core_key_out, 64'd0);
    check({tag, "_core_data"}, core_data_out, 64'd0);
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!req_ready_out && n < 100) begin
      @(negedge clk_in);
      n++;
    end
    check("ready_wait", 64'(req_ready_out), 64'd1);
  endtask

  task automatic wait_rsp(input int budget, output logic [63:0] rd, output logic [1:0] re,
                          output int rc);
    int n = 0;
    while (!rsp_valid_out && n < budget) begin
      @(negedge clk_in);
      n++;
    end
    check("rsp_wait", 64'(rsp_valid_out), 64'd1);
    rd = rsp_data_out;
    re = rsp_err_out;
    rc = cyc;
  endtask

  task automatic send_req(input logic m, input logic [63:0] d, k1, k2, k3);
    @(negedge clk_in);
    req_mode_in = m; req_data_in = d;
    req_key1_in = k1; req_key2_in = k2; req_key3_in = k3;
    req_valid_in = 1'b1;
    @(negedge clk_in);
    req_valid_in = 1'b0;
    req_mode_in = ~m;
    req_data_in = {$urandom, $urandom};
    req_key1_in = {$urandom, $urandom};
    req_key3_in = {$urandom, $urandom};
  endtask

  task automatic run_txn(input logic m, input logic [63:0] d, k1, k2, k3, input int budget,
                         output logic [63:0] rd, output logic [1:0] re, output int rc);
    wait_ready();
    send_req(m, d, k1, k2, k3);
    wait_rsp(budget, rd, re, rc);
    @(negedge clk_in);
    check("ready_after_rsp", 64'(req_ready_out), 64'd1);
    check("valid_after_rsp", 64'(rsp_valid_out), 64'd0);
  endtask

  task automatic check_passes(input string tag, input int base, input logic m,
                              input logic [63:0] k1, k2, k3);
    logic [63:0] ek[3];
    logic [2:0]  em;
    if (m == 1'b0) begin
      ek = '{k1, k2, k3}; em = 3'b010;
    end else begin
      ek = '{k3, k2, k1}; em = 3'b101;
    end
    check({tag, "_starts"}, 64'(starts - base), 64'd3);
    if (log_mode.size() >= base + 3) begin
      check({tag, "_modes"}, 64'({log_mode[base], log_mode[base+1], log_mode[base+2]}), 64'(em));
      for (int i = 0; i < 3; i++) check({tag, "_key"}, log_key[base+i], ek[i]);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: observed no finish expected finish");
    $fatal(1, "bench time limit");
  end

  initial begin
    logic [63:0] rd, rd2, d, k1, k2, k3, d2, b1, b2, b3;
    logic [1:0]  re, re2;
    logic        m, m2;
    int          rc, base, n, seen;

    cal_c = rotr(CT, rn(KV)) ^ PT ^ KV;
    rst_n_in = 1'b0;
    req_valid_in = 1'b0; req_mode_in = 1'b0; req_data_in = '0;
    req_key1_in = '0; req_key2_in = '0; req_key3_in = '0;
    rsp_ready_in = 1'b1; core_ready_in = 1'b1;
    #1;
    check_reset_outputs("reset");
    repeat (3) @(negedge clk_in);
    rst_n_in = 1'b1;

    // known-answer encrypt and decrypt with equal keys
    base = starts;
    run_txn(1'b0, PT, KV, KV, KV, 500, rd, re, rc);
    check("kat_enc_data", rd, CT);
    check("kat_enc_err", 64'(re), 64'd0);
    check_passes("kat_enc", base, 1'b0, KV, KV, KV);
    base = starts;
    run_txn(1'b1, CT, KV, KV, KV, 500, rd, re, rc);
    check("kat_dec_data", rd, PT);
    check("kat_dec_err", 64'(re), 64'd0);
    check_passes("kat_dec", base, 1'b1, KV, KV, KV);

    // random requests with distinct keys and core latencies
    for (int i = 0; i < 6; i++) begin
      m = 1'($urandom_range(0, 1));
      d = {$urandom, $urandom};
      k1 = {$urandom, $urandom}; k2 = {$urandom, $urandom}; k3 = {$urandom, $urandom};
      lcore = $urandom_range(1, 6);
      base = starts;
      run_txn(m, d, k1, k2, k3, 500, rd, re, rc);
      check("rand_data", rd, tdes_model(m, d, k1, k2, k3));
      check("rand_err", 64'(re), 64'd0);
      check_passes("rand", base, m, k1, k2, k3);
    end

    // key error together with done on pass 1
    lcore = 2;
    base = starts;
    err_at = starts + 2;
    run_txn(1'b0, {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom},
            {$urandom, $urandom}, 500, rd, re, rc);
    check("keyerr_err", 64'(re), 64'd1);
    check("keyerr_data", rd, 64'd0);
    repeat (4) @(negedge clk_in);
    check("keyerr_starts", 64'(starts - base), 64'd2);
    err_at = -1;

    // hung core: timeout 255 cycles after pass-0 start, then normal operation
    hang = 1'b1;
    base = starts;
    run_txn(1'b1, {$urandom, $urandom}, KV, KV, KV, 1000, rd, re, rc);
    check("hang_err", 64'(re), 64'd2);
    check("hang_data", rd, 64'd0);
    check("hang_starts", 64'(starts - base), 64'd1);
    if (log_cyc.size() > base) check("hang_latency", 64'(rc - log_cyc[base]), 64'd255);
    hang = 1'b0;
    d = {$urandom, $urandom}; k1 = {$urandom, $urandom}; k2 = {$urandom, $urandom};
    run_txn(1'b0, d, k1, k2, KV, 500, rd, re, rc);
    check("post_hang_data", rd, tdes_model(1'b0, d, k1, k2, KV));
    check("post_hang_err", 64'(re), 64'd0);

    // response back-pressure with a second request queued behind it
    rsp_ready_in = 1'b0;
    lcore = 1;
    d = {$urandom, $urandom}; k1 = {$urandom, $urandom}; k2 = {$urandom, $urandom};
    d2 = {$urandom, $urandom}; b1 = {$urandom, $urandom}; b2 = {$urandom, $urandom};
    b3 = {$urandom, $urandom}; m2 = 1'b1;
    wait_ready();
    @(negedge clk_in);
    req_mode_in = 1'b0; req_data_in = d; req_key1_in = k1; req_key2_in = k2; req_key3_in = k3;
    req_valid_in = 1'b1;
    @(negedge clk_in);
    req_mode_in = m2; req_data_in = d2; req_key1_in = b1; req_key2_in = b2; req_key3_in = b3;
    wait_rsp(500, rd, re, rc);
    check("bp_first_data", rd, tdes_model(1'b0, d, k1, k2, k3));
    for (int i = 0; i < 10; i++) begin
      check("bp_hold_valid", 64'(rsp_valid_out), 64'd1);
      check("bp_hold_data", rsp_data_out, rd);
      check("bp_hold_err", 64'(rsp_err_out), 64'(re));
      check("bp_hold_ready", 64'(req_ready_out), 64'd0);
      @(negedge clk_in);
    end
    rsp_ready_in = 1'b1;
    @(negedge clk_in);
    check("bp_idle_after_hs", 64'(req_ready_out), 64'd1);
    @(negedge clk_in);
    check("bp_second_accepted", 64'(req_ready_out), 64'd0);
    req_valid_in = 1'b0;
    wait_rsp(500, rd2, re2, rc);
    check("bp_second_data", rd2, tdes_model(m2, d2, b1, b2, b3));
    check("bp_second_err", 64'(re2), 64'd0);
    @(negedge clk_in);

    // reset while waiting on pass 1 aborts silently
    lcore = 20;
    base = starts;
    wait_ready();
    send_req(1'b0, {$urandom, $urandom}, KV, k1, k2);
    n = 0;
    while (starts - base < 2 && n < 200) begin
      @(negedge clk_in);
      n++;
    end
    repeat (3) @(negedge clk_in);
    rst_n_in = 1'b0;
    #1;
    check_reset_outputs("midrst");
    @(negedge clk_in);
    @(negedge clk_in);
    rst_n_in = 1'b1;
    base = starts;
    seen = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk_in);
      if (rsp_valid_out) seen++;
    end
    check("midrst_no_rsp", 64'(seen), 64'd0);
    check("midrst_no_start", 64'(starts - base), 64'd0);

    // core not ready for 5 cycles in issue delays the first start by 5
    lcore = 2;
    core_ready_in = 1'b0;
    base = starts;
    d = {$urandom, $urandom};
    wait_ready();
    @(negedge clk_in);
    rc = cyc;
    req_mode_in = 1'b1; req_data_in = d; req_key1_in = k1; req_key2_in = k2; req_key3_in = KV;
    req_valid_in = 1'b1;
    @(negedge clk_in);
    req_valid_in = 1'b0;
    repeat (5) @(negedge clk_in);
    check("rdy_low_no_start", 64'(starts - base), 64'd0);
    core_ready_in = 1'b1;
    wait_rsp(500, rd, re, n);
    if (log_cyc.size() > base) check("rdy_low_start_cycle", 64'(log_cyc[base] - rc), 64'd7);
    check("rdy_low_data", rd, tdes_model(1'b1, d, k1, k2, KV));
    @(negedge clk_in);

    check("single_cycle_start", 64'(dbl_starts), 64'd0);
    check("core_inputs_stable", 64'(stab_err), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
